// File: rtl/fp_addsub_seq.sv
// Sequential single-precision adder/subtractor.
// Operands are captured once and walked through unpack, bit-serial alignment,
// add, iterative normalisation and round-to-nearest-even. Subnormal inputs
// and results are flushed to zero. Any exp==255 operand yields the canonical
// quiet NaN with the invalid flag set.
//
// Handshake: an operand transfer happens on a rising edge where in_valid and
// in_ready are both high; a result transfer happens on a rising edge where
// out_valid and out_ready are both high. in_ready is high only in IDLE and
// out_valid only in DONE, so the two transfers can never share an edge.
// Inputs seen outside IDLE are ignored. Result and flags stay stable until
// the result transfer.
module fp_addsub_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        operator,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        overflow,
   output logic        underflow,
   output logic        invalid,
   output logic        busy,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE
   } state_t;

   state_t      state_q, state_d;

   logic [31:0] a_q, b_q;
   logic        op_q;
   logic        sign_q;     // sign of the larger-magnitude operand
   logic        sub_q;      // effective subtract
   logic [8:0]  exp_q;      // one spare bit so overflow past 254 is visible
   logic [26:0] ma_q, mb_q; // hidden + 23 fraction + guard/round/sticky
   logic [27:0] sum_q;      // carry + working mantissa
   logic [4:0]  cnt_q;      // remaining alignment shifts
   logic        zero_q;     // result is a signed zero
   logic        uf_q;       // zero came from exponent underflow
   logic [31:0] result_q;
   logic        ov_q, ufl_q, inv_q;

   logic [7:0]  ea, eb, d;
   logic        za, zb, nan, sb_eff, swap;
   logic [30:0] mag_a, mag_b;
   logic [26:0] man_a, man_b;
   logic [4:0]  align_cnt;
   logic [27:0] sum;
   logic        inc;
   logic [24:0] rnd;
   logic [8:0]  exp_rnd;

   // Datapath helpers: operand decode, adder and rounding increment.
   always_comb begin
      ea        = a_q[30:23];
      eb        = b_q[30:23];
      za        = (ea == 8'd0);
      zb        = (eb == 8'd0);
      nan       = (ea == 8'hFF) || (eb == 8'hFF);
      sb_eff    = b_q[31] ^ op_q;
      mag_a     = za ? 31'd0 : a_q[30:0];
      mag_b     = zb ? 31'd0 : b_q[30:0];
      swap      = (mag_b > mag_a);
      man_a     = za ? 27'd0 : {1'b1, a_q[22:0], 3'b000};
      man_b     = zb ? 27'd0 : {1'b1, b_q[22:0], 3'b000};
      d         = swap ? (eb - ea) : (ea - eb);
      align_cnt = (d > 8'd27) ? 5'd27 : d[4:0];
      sum       = sub_q ? ({1'b0, ma_q} - {1'b0, mb_q}) : ({1'b0, ma_q} + {1'b0, mb_q});
      inc       = (sum_q[2:0] > 3'b100) || ((sum_q[2:0] == 3'b100) && sum_q[3]);
      rnd       = {1'b0, sum_q[26:3]} + {24'd0, inc};
      exp_rnd   = exp_q + {8'd0, rnd[24]};
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:   if (in_valid) state_d = UNPACK;
         UNPACK: begin
            if (nan)            state_d = DONE;
            else if (d == 8'd0) state_d = ADD;
            else                state_d = ALIGN;
         end
         ALIGN:  if (cnt_q == 5'd1) state_d = ADD;
         ADD: begin
            if (sum == 28'd0)              state_d = ROUND;
            else if (sum[27] || !sum[26])  state_d = NORM;
            else                           state_d = ROUND;
         end
         NORM: begin
            // Leave after a carry fix-up, on underflow, or once this left
            // shift brings the leading one into bit 26.
            if (sum_q[27] || (exp_q == 9'd1) || sum_q[25]) state_d = ROUND;
         end
         ROUND:  state_d = DONE;
         DONE:   if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath registers, advanced according to the current state.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q <= '0; b_q <= '0; op_q <= 1'b0;
         sign_q <= 1'b0; sub_q <= 1'b0; exp_q <= '0;
         ma_q <= '0; mb_q <= '0; sum_q <= '0; cnt_q <= '0;
         zero_q <= 1'b0; uf_q <= 1'b0;
         result_q <= '0; ov_q <= 1'b0; ufl_q <= 1'b0; inv_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               a_q <= a; b_q <= b; op_q <= operator;
               result_q <= '0; ov_q <= 1'b0; ufl_q <= 1'b0; inv_q <= 1'b0;
            end
            UNPACK: begin
               ma_q   <= swap ? man_b : man_a;
               mb_q   <= swap ? man_a : man_b;
               exp_q  <= {1'b0, swap ? eb : ea};
               sign_q <= swap ? sb_eff : a_q[31];
               sub_q  <= a_q[31] ^ sb_eff;
               cnt_q  <= align_cnt;
               zero_q <= 1'b0;
               uf_q   <= 1'b0;
               if (nan) begin
                  result_q <= 32'h7FC0_0000;
                  inv_q    <= 1'b1;
               end
            end
            ALIGN: begin
               mb_q  <= {1'b0, mb_q[26:2], mb_q[1] | mb_q[0]};
               cnt_q <= cnt_q - 5'd1;
            end
            ADD: begin
               sum_q <= sum;
               // Exact zero is +0 unless both operands were effectively negative.
               if (sum == 28'd0) begin
                  zero_q <= 1'b1;
                  sign_q <= sign_q & ~sub_q;
               end
            end
            NORM: begin
               if (sum_q[27]) begin
                  sum_q <= {1'b0, sum_q[27:2], sum_q[1] | sum_q[0]};
                  exp_q <= exp_q + 9'd1;
               end else begin
                  sum_q <= {sum_q[26:0], 1'b0};
                  exp_q <= exp_q - 9'd1;
                  if (exp_q == 9'd1) begin
                     zero_q <= 1'b1;
                     uf_q   <= 1'b1;
                  end
               end
            end
            ROUND: begin
               if (zero_q) begin
                  result_q <= {sign_q, 31'd0};
                  ufl_q    <= uf_q;
               end else if (exp_rnd >= 9'd255) begin
                  result_q <= {sign_q, 8'hFF, 23'd0};
                  ov_q     <= 1'b1;
               end else begin
                  result_q <= {sign_q, exp_rnd[7:0], rnd[24] ? rnd[23:1] : rnd[22:0]};
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign result    = result_q;
   assign overflow  = ov_q;
   assign underflow = ufl_q;
   assign invalid   = inv_q;
   assign state     = state_q;

endmodule
